fpu: RTL and testbench
======================

FPU -- requirements
Module: fpu

Interface
- REQ-001: The module SHALL have no parameters; operation encoding comes from package pa_fpu, enum e_fpu_op: op_add=0, op_sub=1, op_mul=2, op_div=3.
- REQ-002: clk  input  1  single clock; all state updates on rising edge.
- REQ-003: rst_n  input  1  reset, asynchronous, active-low.
- REQ-004: a_operand  input  32  IEEE-754 binary32 first operand.
- REQ-005: b_operand  input  32  IEEE-754 binary32 second operand.
- REQ-006: operation  input  pa_fpu::e_fpu_op  selects a+b, a-b, a*b or a/b.
- REQ-007: ieee_packet_out  output  32  registered binary32 result.

Function
- REQ-008: Result logic SHALL be combinational from a_operand, b_operand and operation; ieee_packet_out SHALL be registered, with latency 1 cycle: inputs present at rising edge N appear at the output after edge N.
- REQ-009: A new operation SHALL be accepted every cycle, with no handshake and no stall.
- REQ-010: op_add SHALL compute a+b; op_sub SHALL compute a+(-b), implemented by inverting b's sign then adding.
- REQ-011: op_mul SHALL compute a*b; the result sign is a[31] XOR b[31], including zero results.
- REQ-012: op_div is unsupported and SHALL return canonical NaN 0x7FC00000.
- REQ-013: Rounding SHALL be round-to-nearest-even, using guard, round and sticky bits.
- REQ-014: Add alignment shift SHALL be capped so that all shifted-out bits feed sticky.
- REQ-015: Add SHALL use a 1-bit carry with renormalisation, plus leading-zero normalisation after cancellation.
- REQ-016: Mul SHALL form a full 24x24 = 48-bit product before normalising.
- REQ-017: Any NaN input SHALL produce canonical NaN 0x7FC00000; input payload and sign are not propagated.
- REQ-018: inf-inf (add of opposite-sign infinities, or sub of like-sign infinities) SHALL produce 0x7FC00000.
- REQ-019: inf*0 in either order SHALL produce 0x7FC00000.
- REQ-020: An infinity with a finite operand SHALL produce an infinity with the sign given by the operation rules.
- REQ-021: Overflow after rounding SHALL produce a signed infinity.
- REQ-022: An exact zero sum of nonzero operands SHALL be +0.
- REQ-023: (+0)+(+0) SHALL be +0, and (-0)+(-0) SHALL be -0.
- REQ-024: x+0 SHALL return x exactly.
- REQ-025: Biased exponent 0 with nonzero fraction is subnormal, with implicit bit 0 and effective exponent -126.
- REQ-026: A result below the normal range SHALL be denormalised by right shift with sticky collection, then rounded.
- REQ-027: Rounding a subnormal up to 0x00800000 SHALL yield the normal encoding.
- REQ-028: Any result rounding below the smallest subnormal SHALL be a signed zero.

Reset
- REQ-029: While rst_n=0, ieee_packet_out SHALL be 0x00000000 immediately, independent of clk.
- REQ-030: After rst_n deasserts, the first rising edge SHALL load the result of the current inputs.
- REQ-031: If reset is asserted mid-stream, any in-flight result SHALL be discarded.

Configuration
- REQ-032: Macro FPU_SUBNORMAL_EN defined: gradual underflow per REQ-025..REQ-028.
- REQ-033: FPU_SUBNORMAL_EN undefined: subnormal inputs SHALL be treated as signed zero of the same sign.
- REQ-034: FPU_SUBNORMAL_EN undefined: any result below 2^-126 after rounding SHALL flush to signed zero, and no subnormal encoding is ever output.

Verification (FPU_SUBNORMAL_EN defined; check one cycle after applying inputs)
- REQ-035: Normal mul: 0x3FFFFFFF * 0x402DF854 -> 0x40ADF853; 0x41800000 * 0x42000000 -> 0x44000000; 0x3E800000 * 0x3F000000 -> 0x3E000000.
- REQ-036: Normal add/sub:
  - 0x3F800000 + 0x3F8CCCCD -> 0x40066666
  - 0x3F800000 - 0x3F8CCCCD -> 0xBDCCCCD0
  - 0x3F800000 - 0x3F800000 -> 0x00000000
  - 0x41800000 - 0x42000000 -> 0xC1800000
- REQ-037: Subnormal:
  - 0x00000001 * 0x41000000 -> 0x00000008
  - 0x00000001 * 0x00000001 -> 0x00000000
  - 0x00000001 * 0x80000001 -> 0x80000000
  - 0x007FFFFF + 0x00000001 -> 0x00800000
  - 0x00400000 + 0x00400000 -> 0x00800000
  - 0x00000001 - 0x00000001 -> 0x00000000
- REQ-038: Specials:
  - 0x7F800000 * 0x00000000 -> 0x7FC00000
  - 0xFF800000 + 0x7F800000 -> 0x7FC00000
  - 0x41200000 - 0xFF800000 -> 0x7F800000
  - 0x7FC00000 * 0x402DF854 -> 0x7FC00000
  - 0xFF800000 * 0xFF800000 -> 0x7F800000
- REQ-039: Overflow/div: 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000; op_div with any operands -> 0x7FC00000.
- REQ-040: Reset mid-stream: assert rst_n=0 between edges -> output 0x00000000 at once; release, then apply 0x3F800000 + 0x3F800000 -> 0x40000000 after the next edge.

Source files
------------

// File: rtl/fpu.sv
// Single-precision add/sub/mul unit with a registered result and one-cycle latency.
// Define FPU_SUBNORMAL_EN for gradual underflow; otherwise subnormals are flushed to signed zero.

package pa_fpu;
   typedef enum logic [1:0] {
      op_add = 2'd0,
      op_sub = 2'd1,
      op_mul = 2'd2,
      op_div = 2'd3
   } e_fpu_op;
endpackage

module fpu (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [31:0]     a_operand,
   input  logic [31:0]     b_operand,
   input  pa_fpu::e_fpu_op operation,
   output logic [31:0]     ieee_packet_out
);

`ifdef FPU_SUBNORMAL_EN
   localparam bit SUBNORMAL_EN = 1'b1;
`else
   localparam bit SUBNORMAL_EN = 1'b0;
`endif

   localparam logic [31:0] QNAN = 32'h7FC0_0000;

   // Right shift that ORs every bit shifted out into bit 0 (sticky).
   function automatic logic [26:0] shift_sticky(input logic [26:0] m, input logic [9:0] sh);
      logic [26:0] res;
      logic        lost;
      if (sh >= 10'd27) begin
         res  = '0;
         lost = |m;
      end else begin
         res  = m >> sh;
         lost = |(m & ~(27'h7FF_FFFF << sh));
      end
      res[0] = res[0] | lost;
      return res;
   endfunction

   function automatic logic [5:0] lzc48(input logic [47:0] v);
      logic [5:0] n;
      n = 6'd48;
      for (int i = 0; i < 48; i++) begin
         if (v[i]) n = 6'(47 - i);
      end
      return n;
   endfunction

   // mant has its leading one at bit 26 and guard/round/sticky in bits 2:0.
   // exp_in below 1 means the value must be denormalised before rounding.
   function automatic logic [31:0] round_pack(input logic sign,
                                              input logic signed [9:0] exp_in,
                                              input logic [26:0] mant);
      logic [26:0]       m;
      logic signed [9:0] e;
      logic              sub;
      logic              inc;
      logic [24:0]       rnd;
      logic [31:0]       res;
      m   = mant;
      e   = exp_in;
      sub = 1'b0;
      if (e < 10'sd1) begin
         m   = shift_sticky(mant, $unsigned(10'sd1 - e));
         sub = 1'b1;
      end
      inc = m[2] & (m[1] | m[0] | m[3]);
      rnd = {1'b0, m[26:3]} + {24'd0, inc};
      if (sub) begin
         // A carry into bit 23 lands exactly on the smallest normal encoding.
         res = {sign, 7'd0, rnd[23:0]};
         if (!SUBNORMAL_EN && !rnd[23]) res = {sign, 31'd0};
      end else begin
         if (rnd[24]) begin
            rnd = rnd >> 1;
            e   = e + 10'sd1;
         end
         if (e >= 10'sd255) res = {sign, 8'hFF, 23'd0};
         else               res = {sign, e[7:0], rnd[22:0]};
      end
      return res;
   endfunction

   logic              a_sign, b_sign, b_sign_eff;
   logic [7:0]        a_exp, b_exp;
   logic [23:0]       a_mant, b_mant;
   logic signed [9:0] a_e, b_e;
   logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

   assign a_sign     = a_operand[31];
   assign b_sign     = b_operand[31];
   assign a_exp      = a_operand[30:23];
   assign b_exp      = b_operand[30:23];
   assign b_sign_eff = b_sign ^ (operation == pa_fpu::op_sub);

   assign a_nan  = (a_exp == 8'hFF) && (a_operand[22:0] != 23'd0);
   assign b_nan  = (b_exp == 8'hFF) && (b_operand[22:0] != 23'd0);
   assign a_inf  = (a_exp == 8'hFF) && (a_operand[22:0] == 23'd0);
   assign b_inf  = (b_exp == 8'hFF) && (b_operand[22:0] == 23'd0);

   // Subnormals use exponent 1 with a zero implicit bit, or vanish when flushing.
   assign a_mant = (a_exp == 8'd0) ? (SUBNORMAL_EN ? {1'b0, a_operand[22:0]} : 24'd0)
                                   : {1'b1, a_operand[22:0]};
   assign b_mant = (b_exp == 8'd0) ? (SUBNORMAL_EN ? {1'b0, b_operand[22:0]} : 24'd0)
                                   : {1'b1, b_operand[22:0]};
   assign a_e    = (a_exp == 8'd0) ? 10'sd1 : $signed({2'b00, a_exp});
   assign b_e    = (b_exp == 8'd0) ? 10'sd1 : $signed({2'b00, b_exp});
   assign a_zero = (a_mant == 24'd0);
   assign b_zero = (b_mant == 24'd0);

   logic              add_swap;
   logic [23:0]       big_m, small_m;
   logic signed [9:0] big_e, small_e, add_e;
   logic              big_s;
   logic [26:0]       small_al, add_mant;
   logic [27:0]       add_raw;
   logic [5:0]        add_lz;
   logic [31:0]       add_res;

   always_comb begin
      add_swap = (b_e > a_e) || ((b_e == a_e) && (b_mant > a_mant));
      big_m    = add_swap ? b_mant : a_mant;
      small_m  = add_swap ? a_mant : b_mant;
      big_e    = add_swap ? b_e : a_e;
      small_e  = add_swap ? a_e : b_e;
      big_s    = add_swap ? b_sign_eff : a_sign;
      small_al = shift_sticky({small_m, 3'd0}, $unsigned(big_e - small_e));
      if (a_sign == b_sign_eff) add_raw = {1'b0, big_m, 3'd0} + {1'b0, small_al};
      else                      add_raw = {1'b0, big_m, 3'd0} - {1'b0, small_al};
      add_lz   = 6'd0;
      add_mant = add_raw[26:0];
      add_e    = big_e;
      if (add_raw[27]) begin
         add_mant = {add_raw[27:2], add_raw[1] | add_raw[0]};
         add_e    = big_e + 10'sd1;
      end else begin
         add_lz   = lzc48({add_raw[26:0], 21'd0});
         add_mant = add_raw[26:0] << add_lz;
         add_e    = big_e - $signed({4'd0, add_lz});
      end
      // Cancellation to zero is +0 unless both addends are negative zeros.
      if (add_raw == 28'd0) add_res = {a_sign & b_sign_eff, 31'd0};
      else                  add_res = round_pack(big_s, add_e, add_mant);
   end

   logic              mul_sign;
   logic [47:0]       prod, prod_norm;
   logic [5:0]        mul_lz;
   logic signed [9:0] mul_e;
   logic [31:0]       mul_res;

   always_comb begin
      mul_sign  = a_sign ^ b_sign;
      prod      = a_mant * b_mant;
      mul_lz    = lzc48(prod);
      prod_norm = prod << mul_lz;
      mul_e     = a_e + b_e - 10'sd126 - $signed({4'd0, mul_lz});
      if (prod == 48'd0) mul_res = {mul_sign, 31'd0};
      else mul_res = round_pack(mul_sign, mul_e,
                                {prod_norm[47:22], prod_norm[21] | (|prod_norm[20:0])});
   end

   logic [31:0] result_d, result_q;

   always_comb begin
      result_d = QNAN;
      case (operation)
         pa_fpu::op_add, pa_fpu::op_sub: begin
            if (a_nan || b_nan)      result_d = QNAN;
            else if (a_inf && b_inf) result_d = (a_sign != b_sign_eff) ? QNAN : {a_sign, 8'hFF, 23'd0};
            else if (a_inf)          result_d = {a_sign, 8'hFF, 23'd0};
            else if (b_inf)          result_d = {b_sign_eff, 8'hFF, 23'd0};
            else                     result_d = add_res;
         end
         pa_fpu::op_mul: begin
            if (a_nan || b_nan)                          result_d = QNAN;
            else if ((a_inf && b_zero) || (b_inf && a_zero)) result_d = QNAN;
            else if (a_inf || b_inf)                     result_d = {mul_sign, 8'hFF, 23'd0};
            else                                         result_d = mul_res;
         end
         default: result_d = QNAN;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) result_q <= 32'd0;
      else        result_q <= result_d;
   end

   assign ieee_packet_out = result_q;

endmodule

// File: tb/tb_fpu.sv
// Directed self-checking bench for fpu; subnormal expectations follow FPU_SUBNORMAL_EN.

module tb_fpu;
   logic            clk;
   logic            rst_n;
   logic [31:0]     a_operand;
   logic [31:0]     b_operand;
   pa_fpu::e_fpu_op operation;
   logic [31:0]     ieee_packet_out;

   int checkCount = 0;
   int passCount  = 0;

`ifdef FPU_SUBNORMAL_EN
   localparam logic [31:0] EXP_SUB_MUL8   = 32'h0000_0008;
   localparam logic [31:0] EXP_SUB_ADDTOP = 32'h0080_0000;
   localparam logic [31:0] EXP_SUB_ADDHLF = 32'h0080_0000;
`else
   localparam logic [31:0] EXP_SUB_MUL8   = 32'h0000_0000;
   localparam logic [31:0] EXP_SUB_ADDTOP = 32'h0000_0000;
   localparam logic [31:0] EXP_SUB_ADDHLF = 32'h0000_0000;
`endif

   fpu dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .a_operand       (a_operand),
      .b_operand       (b_operand),
      .operation       (operation),
      .ieee_packet_out (ieee_packet_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] expected);
      checkCount++;
      assert (ieee_packet_out === expected) passCount++;
      else $error("[TB] FAIL %s: observed %h expected %h", tag, ieee_packet_out, expected);
   endtask

   // Drives one operation, lets one rising edge capture it, then checks just after.
   task automatic applyStimulus(input string tag, input logic [31:0] a, input logic [31:0] b,
                                input pa_fpu::e_fpu_op op, input logic [31:0] expected);
      a_operand = a;
      b_operand = b;
      operation = op;
      @(posedge clk);
      #1;
      checkOutput(tag, expected);
   endtask

   initial begin
      rst_n     = 1'b0;
      a_operand = 32'h3F80_0000;
      b_operand = 32'h3F80_0000;
      operation = pa_fpu::op_add;
      @(posedge clk);
      @(posedge clk);
      #1;
      checkOutput("reset_hold", 32'h0000_0000);
      rst_n = 1'b1;

      applyStimulus("mul_norm1", 32'h3FFF_FFFF, 32'h402D_F854, pa_fpu::op_mul, 32'h40AD_F853);
      applyStimulus("mul_norm2", 32'h4180_0000, 32'h4200_0000, pa_fpu::op_mul, 32'h4400_0000);
      applyStimulus("mul_norm3", 32'h3E80_0000, 32'h3F00_0000, pa_fpu::op_mul, 32'h3E00_0000);
      applyStimulus("add_norm",  32'h3F80_0000, 32'h3F8C_CCCD, pa_fpu::op_add, 32'h4006_6666);
      applyStimulus("sub_norm",  32'h3F80_0000, 32'h3F8C_CCCD, pa_fpu::op_sub, 32'hBDCC_CCD0);
      applyStimulus("sub_cancel", 32'h3F80_0000, 32'h3F80_0000, pa_fpu::op_sub, 32'h0000_0000);
      applyStimulus("sub_neg",   32'h4180_0000, 32'h4200_0000, pa_fpu::op_sub, 32'hC180_0000);

      applyStimulus("sub_mul8",  32'h0000_0001, 32'h4100_0000, pa_fpu::op_mul, EXP_SUB_MUL8);
      applyStimulus("sub_mul_uf", 32'h0000_0001, 32'h0000_0001, pa_fpu::op_mul, 32'h0000_0000);
      applyStimulus("sub_mul_neg", 32'h0000_0001, 32'h8000_0001, pa_fpu::op_mul, 32'h8000_0000);
      applyStimulus("sub_add_top", 32'h007F_FFFF, 32'h0000_0001, pa_fpu::op_add, EXP_SUB_ADDTOP);
      applyStimulus("sub_add_half", 32'h0040_0000, 32'h0040_0000, pa_fpu::op_add, EXP_SUB_ADDHLF);
      applyStimulus("sub_sub_zero", 32'h0000_0001, 32'h0000_0001, pa_fpu::op_sub, 32'h0000_0000);

      applyStimulus("inf_times_0", 32'h7F80_0000, 32'h0000_0000, pa_fpu::op_mul, 32'h7FC0_0000);
      applyStimulus("zero_times_inf", 32'h0000_0000, 32'hFF80_0000, pa_fpu::op_mul, 32'h7FC0_0000);
      applyStimulus("inf_minus_inf", 32'hFF80_0000, 32'h7F80_0000, pa_fpu::op_add, 32'h7FC0_0000);
      applyStimulus("fin_sub_ninf", 32'h4120_0000, 32'hFF80_0000, pa_fpu::op_sub, 32'h7F80_0000);
      applyStimulus("nan_mul",   32'h7FC0_0000, 32'h402D_F854, pa_fpu::op_mul, 32'h7FC0_0000);
      applyStimulus("nan_payload_add", 32'hFFC1_2345, 32'h3F80_0000, pa_fpu::op_add, 32'h7FC0_0000);
      applyStimulus("ninf_sq",   32'hFF80_0000, 32'hFF80_0000, pa_fpu::op_mul, 32'h7F80_0000);
      applyStimulus("add_ovf",   32'h7F7F_FFFF, 32'h7F7F_FFFF, pa_fpu::op_add, 32'h7F80_0000);
      applyStimulus("mul_ovf",   32'h7F00_0000, 32'h4000_0000, pa_fpu::op_mul, 32'h7F80_0000);
      applyStimulus("div_nan",   32'h3F80_0000, 32'h4000_0000, pa_fpu::op_div, 32'h7FC0_0000);
      applyStimulus("add_x_zero", 32'h4049_0FDB, 32'h0000_0000, pa_fpu::op_add, 32'h4049_0FDB);
      applyStimulus("negz_plus_negz", 32'h8000_0000, 32'h8000_0000, pa_fpu::op_add, 32'h8000_0000);
      applyStimulus("posz_plus_posz", 32'h0000_0000, 32'h0000_0000, pa_fpu::op_add, 32'h0000_0000);
      applyStimulus("negz_times_one", 32'h8000_0000, 32'h3F80_0000, pa_fpu::op_mul, 32'h8000_0000);

      applyStimulus("pre_reset", 32'h4180_0000, 32'h4200_0000, pa_fpu::op_mul, 32'h4400_0000);
      a_operand = 32'h4000_0000;
      b_operand = 32'h4000_0000;
      operation = pa_fpu::op_mul;
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("reset_async", 32'h0000_0000);
      @(posedge clk);
      #1;
      checkOutput("reset_discard", 32'h0000_0000);
      rst_n = 1'b1;
      applyStimulus("post_reset", 32'h3F80_0000, 32'h3F80_0000, pa_fpu::op_add, 32'h4000_0000);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
